// File: rtl/sram8_wb_controller.sv
// Wishbone classic slave that splits 32-bit accesses into byte cycles on a
// 4-chip async 8-bit SRAM bank (chip select, strobe timing, lane packing).
`timescale 1ns/1ps
module sram8_wb_controller #(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2,
    parameter int ADDR_W  = 21
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [31:0]       i_wb_adr,
    input  logic [3:0]        i_wb_sel,
    input  logic              i_wb_we,
    input  logic [31:0]       i_wb_dat,
    output logic [31:0]       o_wb_dat,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    output logic              o_wb_ack,
    output logic              o_wb_err,
    output logic [3:0]        o_sram_cs,
    output logic              o_sram_read,
    output logic              o_sram_write,
    output logic [ADDR_W-1:0] o_sram_addr,
    inout  wire  [7:0]        io_sram_data,
    output logic [2:0]        o_dbg_state
);

    localparam int AW = ADDR_W + 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_RSTROBE = 3'd2,
        S_WSTROBE = 3'd3,
        S_HOLD    = 3'd4,
        S_ACK     = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:2] adr_q;
    logic [3:0]    pend_q;
    logic          we_q;
    logic [31:0]   wdat_q;
    logic [31:0]   rd_buf;
    logic [1:0]    lane_q;
    logic [3:0]    cnt_q;
    logic          abort_q;
    logic          data_oe;
    logic          accept;
    logic          abort_now;
    logic          rd_last;
    logic          wr_last;
    logic [1:0]    next_lane;
    logic [1:0]    start_lane;
    logic          unused_adr;

    function automatic logic [1:0] first_lane(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Handshake: a request is taken in IDLE while cyc & stb are high and ack is
    // low; ack is a one-cycle pulse, and dropping cyc mid-access aborts without ack.
    assign accept     = (state_q == S_IDLE) && i_wb_cyc && i_wb_stb && !o_wb_ack;
    assign abort_now  = abort_q || !i_wb_cyc;
    assign rd_last    = (cnt_q == 4'(RD_WAIT - 1));
    assign wr_last    = (cnt_q == 4'(WR_WAIT - 1));
    assign next_lane  = first_lane(pend_q);
    assign start_lane = first_lane(i_wb_sel);
    assign unused_adr = &{1'b0, i_wb_adr[31:AW], i_wb_adr[1:0]};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = (i_wb_sel == 4'b0000) ? S_ACK : S_SETUP;
            end
            S_SETUP:   state_d = we_q ? S_WSTROBE : S_RSTROBE;
            S_RSTROBE: if (rd_last) state_d = S_HOLD;
            S_WSTROBE: if (wr_last) state_d = S_HOLD;
            S_HOLD: begin
                // The lane in flight always finishes its HOLD before an abort takes effect.
                if (abort_now)           state_d = S_IDLE;
                else if (pend_q != 4'b0) state_d = S_SETUP;
                else                     state_d = S_ACK;
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_sram_cs    = 4'b0000;
        o_sram_read  = 1'b0;
        o_sram_write = 1'b0;
        o_wb_ack     = 1'b0;
        data_oe      = 1'b0;
        case (state_q)
            S_SETUP: begin
                o_sram_cs = 4'b0001 << adr_q[AW-1:ADDR_W];
                data_oe   = we_q;
            end
            S_RSTROBE: begin
                o_sram_cs   = 4'b0001 << adr_q[AW-1:ADDR_W];
                o_sram_read = 1'b1;
            end
            S_WSTROBE: begin
                o_sram_cs    = 4'b0001 << adr_q[AW-1:ADDR_W];
                o_sram_write = 1'b1;
                data_oe      = 1'b1;
            end
            S_HOLD: begin
                o_sram_cs = 4'b0001 << adr_q[AW-1:ADDR_W];
                data_oe   = we_q;
            end
            S_ACK:   o_wb_ack = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            adr_q    <= '0;
            pend_q   <= '0;
            we_q     <= 1'b0;
            wdat_q   <= '0;
            rd_buf   <= '0;
            lane_q   <= '0;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
            o_wb_dat <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        adr_q   <= i_wb_adr[AW-1:2];
                        we_q    <= i_wb_we;
                        wdat_q  <= i_wb_dat;
                        lane_q  <= start_lane;
                        pend_q  <= i_wb_sel & ~(4'b0001 << start_lane);
                        rd_buf  <= '0;
                        abort_q <= 1'b0;
                        if (i_wb_sel == 4'b0000 && !i_wb_we) o_wb_dat <= '0;
                    end
                end
                S_SETUP: cnt_q <= '0;
                S_RSTROBE: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (rd_last) rd_buf[{lane_q, 3'b000} +: 8] <= io_sram_data;
                end
                S_WSTROBE: cnt_q <= cnt_q + 4'd1;
                S_HOLD: begin
                    if (state_d == S_SETUP) begin
                        lane_q <= next_lane;
                        pend_q <= pend_q & ~(4'b0001 << next_lane);
                    end
                    if (state_d == S_ACK && !we_q) o_wb_dat <= rd_buf;
                end
                default: ;
            endcase
            if (state_q inside {S_SETUP, S_RSTROBE, S_WSTROBE, S_HOLD} && !i_wb_cyc)
                abort_q <= 1'b1;
        end
    end

    assign io_sram_data = data_oe ? wdat_q[{lane_q, 3'b000} +: 8] : 8'bzzzz_zzzz;
    assign o_sram_addr  = {adr_q[ADDR_W-1:2], lane_q};
    assign o_wb_err     = 1'b0;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_sram8_wb_controller.sv
// Bench for sram8_wb_controller: directed cases plus random traffic against a
// byte-array reference model, with an ack-driven scoreboard monitor.
`timescale 1ns/1ps
module tb_sram8_wb_controller;

    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 2;
    localparam int ADDR_W  = 21;

    logic              i_clk = 1'b0;
    logic              i_reset_n = 1'b0;
    logic [31:0]       i_wb_adr = '0;
    logic [3:0]        i_wb_sel = '0;
    logic              i_wb_we = 1'b0;
    logic [31:0]       i_wb_dat = '0;
    logic [31:0]       o_wb_dat;
    logic              i_wb_cyc = 1'b0;
    logic              i_wb_stb = 1'b0;
    logic              o_wb_ack;
    logic              o_wb_err;
    logic [3:0]        o_sram_cs;
    logic              o_sram_read;
    logic              o_sram_write;
    logic [ADDR_W-1:0] o_sram_addr;
    wire  [7:0]        io_sram_data;
    logic [2:0]        o_dbg_state;

    sram8_wb_controller #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .ADDR_W(ADDR_W)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_wb_adr(i_wb_adr), .i_wb_sel(i_wb_sel),
        .i_wb_we(i_wb_we), .i_wb_dat(i_wb_dat), .o_wb_dat(o_wb_dat), .i_wb_cyc(i_wb_cyc),
        .i_wb_stb(i_wb_stb), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err), .o_sram_cs(o_sram_cs),
        .o_sram_read(o_sram_read), .o_sram_write(o_sram_write), .o_sram_addr(o_sram_addr),
        .io_sram_data(io_sram_data), .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    int ecount = 0;
    initial forever begin
        @(posedge i_clk);
        ecount++;
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];
    int          exp_lat_q[$];
    int          acc_q[$];
    logic [7:0]  ref_mem[int];
    logic [31:0] last_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    function automatic int ref_key(input logic [31:0] adr, input int lane);
        return int'({adr[22:21], adr[20:2], 2'(lane)});
    endfunction

    // Reference: lanes in the word, per-lane cost 2+WAIT, ack one cycle later.
    task automatic model_issue(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                               input logic [31:0] dat, input int acc_edge);
        logic [31:0] exp_dat;
        int          n;
        n = $countones(sel);
        exp_dat = '0;
        if (we) begin
            for (int l = 0; l < 4; l++)
                if (sel[l]) ref_mem[ref_key(adr, l)] = dat[8*l +: 8];
            exp_dat = last_rd;
            exp_lat_q.push_back(1 + n * (2 + WR_WAIT));
        end else begin
            for (int l = 0; l < 4; l++)
                if (sel[l] && ref_mem.exists(ref_key(adr, l))) exp_dat[8*l +: 8] = ref_mem[ref_key(adr, l)];
            last_rd = exp_dat;
            exp_lat_q.push_back(1 + n * (2 + RD_WAIT));
        end
        exp_q.push_back(exp_dat);
        acc_q.push_back(acc_edge);
    endtask

    // ---------------- SRAM device model ----------------
    logic [7:0] dev_mem[int];
    logic [7:0] dev_rd = '0;
    logic       force_bus = 1'b0;
    logic       tb_oe;
    logic [7:0] tb_dq;
    int         wr_strobes = 0, rd_strobes = 0, cs_cycles = 0, prot_err = 0, ack_total = 0;
    logic [3:0] last_cs = '0;

    assign tb_oe = force_bus | o_sram_read;
    assign tb_dq = force_bus ? 8'h5A : dev_rd;
    assign io_sram_data = tb_oe ? tb_dq : 8'bzzzz_zzzz;

    function automatic int cs_index(input logic [3:0] cs);
        case (cs)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] dev_byte(input int k);
        if (dev_mem.exists(k)) return dev_mem[k];
        return 8'h00;
    endfunction

    task automatic prot_note(input string what);
        prot_err++;
        if (prot_err <= 10) $display("protocol violation at edge %0d: %s", ecount, what);
    endtask

    initial begin : device
        int   k;
        int   rd_run, wr_run;
        logic prev_rd, prev_wr, prev_ack;
        rd_run = 0; wr_run = 0; prev_rd = 0; prev_wr = 0; prev_ack = 0;
        forever begin
            @(negedge i_clk);
            if (!i_reset_n) begin
                rd_run = 0; wr_run = 0; prev_rd = 0; prev_wr = 0; prev_ack = 0;
            end else begin
                k = int'({2'(cs_index(o_sram_cs)), o_sram_addr});
                if (o_sram_cs != 4'b0) begin
                    cs_cycles++;
                    last_cs = o_sram_cs;
                end
                if ($countones(o_sram_cs) > 1) prot_note("cs not one-hot");
                if ((o_sram_read || o_sram_write) && o_sram_cs == 4'b0) prot_note("strobe without cs");
                if (o_sram_read && o_sram_write) prot_note("read and write together");
                if (o_wb_ack && prev_ack) prot_note("ack longer than one cycle");
                if (o_sram_read) dev_rd = dev_byte(k);
                if (o_sram_write) dev_mem[k] = io_sram_data;
                if (o_sram_read && !prev_rd) rd_strobes++;
                if (o_sram_write && !prev_wr) wr_strobes++;
                if (o_sram_read) rd_run++;
                else if (rd_run != 0) begin
                    if (rd_run != RD_WAIT) prot_note("read strobe width");
                    rd_run = 0;
                end
                if (o_sram_write) wr_run++;
                else if (wr_run != 0) begin
                    if (wr_run != WR_WAIT) prot_note("write strobe width");
                    wr_run = 0;
                end
                prev_rd = o_sram_read; prev_wr = o_sram_write; prev_ack = o_wb_ack;
            end
        end
    end

    // ---------------- monitor: pops on every ack ----------------
    initial begin : monitor
        logic [31:0] exp_dat;
        int          lat, acc;
        forever begin
            @(negedge i_clk);
            if (i_reset_n && o_wb_ack) begin
                ack_total++;
                if (exp_q.size() == 0) begin
                    check("ack_without_request", 32'(o_wb_ack), 32'd0);
                end else begin
                    exp_dat = exp_q.pop_front();
                    lat = exp_lat_q.pop_front();
                    acc = acc_q.pop_front();
                    check("ack_data", o_wb_dat, exp_dat);
                    check("ack_latency", 32'(ecount - acc + 1), 32'(lat));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wb_start(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
        i_wb_adr = adr;  i_wb_sel = sel;  i_wb_dat = dat;
    endtask

    task automatic wb_end();
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    endtask

    task automatic wait_ack();
        bit seen;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (o_wb_ack) seen = 1;
            else @(negedge i_clk);
        end
        if (!seen) check("ack_timeout", 32'(o_wb_ack), 32'd1);
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input bit scramble);
        model_issue(we, adr, sel, dat, ecount + 1);
        wb_start(we, adr, sel, dat);
        @(negedge i_clk);
        if (scramble && !o_wb_ack) begin
            i_wb_we  = 1'($urandom_range(0, 1));
            i_wb_adr = $urandom;
            i_wb_sel = 4'($urandom_range(0, 15));
            i_wb_dat = $urandom;
        end
        wait_ack();
        wb_end();
        @(negedge i_clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int   base, mism, k0;
        logic [7:0] fw_bytes [4];
        fw_bytes = '{8'h44, 8'h33, 8'h22, 8'h11};

        repeat (3) @(negedge i_clk);
        check("rst_ack", 32'(o_wb_ack), 32'd0);
        check("rst_cs", 32'(o_sram_cs), 32'd0);
        check("rst_strobes", 32'({o_sram_read, o_sram_write}), 32'd0);
        check("rst_addr", 32'(o_sram_addr), 32'd0);
        check("rst_wb_dat", o_wb_dat, 32'd0);
        check("rst_state_idle", 32'(o_dbg_state), 32'd0);
        i_reset_n = 1'b1;
        @(negedge i_clk);

        // Full-word write to chip 0
        base = wr_strobes;
        wb_xfer(1'b1, 32'h0000_0010, 4'b1111, 32'h1122_3344, 1'b0);
        check("fw_write_strobes", 32'(wr_strobes - base), 32'd4);
        check("fw_cs", 32'(last_cs), 32'b0001);
        for (int l = 0; l < 4; l++)
            check("fw_sram_byte", 32'(dev_byte(32'h10 + l)), 32'(fw_bytes[l]));

        // Partial read from chip 3, lanes 0 and 2
        dev_mem[(3 << 21) | 32'h20] = 8'hAA; ref_mem[(3 << 21) | 32'h20] = 8'hAA;
        dev_mem[(3 << 21) | 32'h22] = 8'hCC; ref_mem[(3 << 21) | 32'h22] = 8'hCC;
        base = rd_strobes;
        wb_xfer(1'b0, 32'h0060_0020, 4'b0101, 32'h0, 1'b0);
        check("pr_read_strobes", 32'(rd_strobes - base), 32'd2);
        check("pr_cs", 32'(last_cs), 32'b1000);
        check("pr_wb_dat", o_wb_dat, 32'h00CC_00AA);

        // Reset asserted during lane 1 write strobe
        base = ack_total;
        wb_start(1'b1, 32'h0000_0200, 4'b1111, 32'h5566_7788);
        repeat (6) @(negedge i_clk);
        #2;
        force_bus = 1'b1;
        i_reset_n = 1'b0;
        #1;
        check("midrst_cs", 32'(o_sram_cs), 32'd0);
        check("midrst_strobes", 32'({o_sram_read, o_sram_write}), 32'd0);
        check("midrst_addr", 32'(o_sram_addr), 32'd0);
        check("midrst_ack", 32'(o_wb_ack), 32'd0);
        check("midrst_wb_dat", o_wb_dat, 32'd0);
        check("midrst_bus_released", 32'(io_sram_data), 32'h5A);
        wb_end();
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        force_bus = 1'b0;
        last_rd = '0;
        ref_mem[ref_key(32'h200, 0)] = 8'h88;
        ref_mem[ref_key(32'h200, 1)] = 8'h77;
        repeat (10) @(negedge i_clk);
        check("midrst_no_ack", 32'(ack_total - base), 32'd0);

        // sel=0000 read: no SRAM activity
        base = cs_cycles;
        k0 = rd_strobes + wr_strobes;
        wb_xfer(1'b0, 32'h0020_0040, 4'b0000, 32'h0, 1'b0);
        check("sel0_cs_cycles", 32'(cs_cycles - base), 32'd0);
        check("sel0_strobes", 32'(rd_strobes + wr_strobes - k0), 32'd0);

        // stb held across ack: second request only taken after the ack cycle
        model_issue(1'b0, 32'h0000_0000, 4'b0000, 32'h0, ecount + 1);
        model_issue(1'b0, 32'h0000_0000, 4'b0000, 32'h0, ecount + 3);
        wb_start(1'b0, 32'h0000_0000, 4'b0000, 32'h0);
        @(negedge i_clk);
        wait_ack();
        @(negedge i_clk);
        wait_ack();
        wb_end();
        @(negedge i_clk);

        // Abort: cyc drops during lane 1 write strobe
        base = wr_strobes;
        k0 = ack_total;
        wb_start(1'b1, 32'h0040_0100, 4'b1111, 32'hA1B2_C3D4);
        repeat (6) @(negedge i_clk);
        wb_end();
        repeat (2) @(negedge i_clk);
        check("abort_hold_cs", 32'(o_sram_cs), 32'b0100);
        @(negedge i_clk);
        check("abort_cs_dropped", 32'(o_sram_cs), 32'd0);
        repeat (10) @(negedge i_clk);
        check("abort_write_strobes", 32'(wr_strobes - base), 32'd2);
        check("abort_no_ack", 32'(ack_total - k0), 32'd0);
        ref_mem[ref_key(32'h0040_0100, 0)] = 8'hD4;
        ref_mem[ref_key(32'h0040_0100, 1)] = 8'hC3;

        // Random back-to-back traffic across all chips
        for (int t = 0; t < 120; t++) begin
            logic [31:0] adr;
            adr = {9'($urandom), 2'($urandom_range(0, 3)), 19'($urandom_range(64, 71)), 2'b00};
            wb_xfer(1'($urandom_range(0, 1)), adr, 4'($urandom_range(0, 15)), $urandom,
                    1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
        end

        repeat (5) @(negedge i_clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("protocol", 32'(prot_err), 32'd0);
        check("wb_err", 32'(o_wb_err), 32'd0);
        mism = 0;
        foreach (ref_mem[k]) if (dev_byte(k) !== ref_mem[k]) mism++;
        check("sram_image", 32'(mism), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram8_wb_controller.md
Name: sram8_wb_controller

Overview:
- Wishbone classic slave that converts 32-bit CPU/DMA accesses into sequenced byte cycles on the 2Mx8 async SRAM bank (4 chips, 8 MB total).
- Sits between the system Wishbone interconnect and the SRAM pins.
- Owns chip-select decode, read/write strobe timing, data-bus direction and byte-lane packing.

Parameters:
- RD_WAIT, 2, cycles o_sram_read is held asserted per byte (legal range 1..15).
- WR_WAIT, 2, cycles o_sram_write is held asserted per byte (legal range 1..15).
- ADDR_W, 21, SRAM per-chip address width.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_wb_adr  in  32  byte address; bits [22:0] used, [31:23] ignored (decoded upstream).
- i_wb_sel  in  4  byte-lane selects.
- i_wb_we  in  1  1 = write.
- i_wb_dat  in  32  write data.
- o_wb_dat  out  32  read data.
- i_wb_cyc  in  1  bus cycle.
- i_wb_stb  in  1  strobe.
- o_wb_ack  out  1  one-cycle acknowledge.
- o_wb_err  out  1  tied 0.
- o_sram_cs  out  4  one-hot chip select, active high (inverted at pad level).
- o_sram_read  out  1  output-enable, active high.
- o_sram_write  out  1  write strobe, active high.
- o_sram_addr  out  ADDR_W  byte address within chip.
- io_sram_data  inout  8  SRAM data; driven only during write phases, else Z.

Behaviour:
- Reset (async, i_reset_n=0): o_sram_cs=0, o_sram_read=0, o_sram_write=0, o_sram_addr=0, io_sram_data=Z, o_wb_ack=0, o_wb_dat=0, FSM=IDLE. Reset mid-transaction forces these values immediately; no ack is issued.
- Request accepted in IDLE when i_wb_cyc & i_wb_stb & !o_wb_ack. Latch adr, sel, we and write data on that edge.
- Chip = adr[22:21], one-hot onto o_sram_cs. Lane n maps to SRAM address {adr[20:2], n[1:0]} (little endian) and data bits [8n+7:8n].
- Lanes are processed in ascending order, 0..3; lanes with sel=0 are skipped entirely.
- Per selected lane, write: SETUP (1 cycle: cs, addr, data driven, write=0) -> WSTROBE (WR_WAIT cycles, write=1) -> HOLD (1 cycle: write=0, data and addr still held).
- Per selected lane, read: SETUP (1 cycle: cs, addr, read=0) -> RSTROBE (RD_WAIT cycles, read=1; io_sram_data sampled into the lane on the last RSTROBE cycle) -> HOLD (1 cycle: read=0).
- Per-lane cost is 2+WAIT cycles. o_sram_cs stays asserted from the first SETUP through the last HOLD, then drops.
- read and write are never asserted together. The data bus is never driven while read=1.
- ACK state: o_wb_ack=1 for exactly one cycle, then IDLE.
- Ack latency: ack is high in cycle 1 + N*(2+WAIT) after the accepting edge, where N = number of selected lanes. With N=0 (sel=0), ack comes in cycle 1 and there is no SRAM activity.
- o_wb_dat: updated only on read completion. Selected lanes carry captured bytes; unselected lanes read 0x00. Value holds until the next read completes.
- Abort: if i_wb_cyc drops mid-transaction, the current lane completes through HOLD (SRAM timing preserved). The FSM then returns to IDLE with no ack, and remaining lanes are not accessed.
- Back-to-back: a new request is accepted no earlier than the cycle after ack. i_wb_stb held high across the ack cycle is not re-accepted until the cycle after.
- i_wb_we, adr and sel changes during a transaction are ignored (latched copies are used).

Test Plan:
- Reset: assert i_reset_n=0 mid-write -> all outputs at reset values within the same cycle, io_sram_data=Z, no ack after release.
- Full-word write: adr=0x00000010, sel=1111, dat=0x11223344, RD/WR_WAIT=2 -> cs=0001; four write strobes, each 2 cycles, at addr 0x10,0x11,0x12,0x13 with bytes 0x44,0x33,0x22,0x11; ack in cycle 17.
- Partial read: adr=0x00600020, sel=0101, SRAM model holds 0xAA@0x20 and 0xCC@0x22 -> cs=1000; two read strobes only; o_wb_dat=0x00CC00AA; ack in cycle 9.
- sel=0000 read -> no cs/read/write activity; ack in cycle 1.
- Abort: write sel=1111, drop i_wb_cyc during lane 1 WSTROBE -> lane 1 completes HOLD; lanes 2–3 are never strobed; no ack; cs=0 afterwards.
- Stress: random back-to-back reads/writes across all 4 chips versus a byte-array SRAM model. Scoreboard match; assertion checks: read&write never both 1, bus not driven while read=1, ack is always a single-cycle pulse.
